// File: rtl/axi2mem_tcdm_wr_if_pkg.sv
// Shared constants, state encoding and address helper for the axi2mem TCDM write interface.
`default_nettype none

package axi2mem_tcdm_wr_if_pkg;

  localparam int unsigned BEAT_BYTES = 8;
  localparam int unsigned LANE_BYTES = 4;
  localparam int unsigned NUM_LANES  = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  typedef struct packed {
    logic [31:0] add;
    logic [7:0]  len;
  } burst_cmd_t;

  // Byte address of one lane of a beat; wraps modulo 2^32.
  function automatic logic [31:0] lane_addr(input logic [31:0] base, input logic [8:0] beat,
                                            input int unsigned lane);
    return base + {20'd0, beat, 3'd0} + 32'(lane * LANE_BYTES);
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi2mem_tcdm_wr_lane.sv
// One 32-bit lane: beat and outstanding counters, TCDM request, buffer pop and completion flag.
`default_nettype none

module axi2mem_tcdm_wr_lane
  import axi2mem_tcdm_wr_if_pkg::*;
#(
  parameter int unsigned LANE            = 0,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        active,
  input  logic [31:0] base,
  input  logic [7:0]  len,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        pop,
  output logic        req,
  output logic        wen,
  output logic [31:0] add,
  output logic [3:0]  be,
  output logic [31:0] data,
  input  logic        gnt,
  input  logic        r_valid,
  output logic        done
);

  logic [8:0] beat;
  logic [3:0] outst;
  logic       in_range;
  logic       zero_strb;
  logic       issue;
  logic       skip;
  logic       ack;

  assign in_range  = beat <= {1'b0, len};
  assign zero_strb = (wstrb == 4'd0);

  // Fully masked beats are drained from the buffer without touching memory.
  assign req   = active & wvalid & in_range & ~zero_strb & (outst < 4'(MAX_OUTSTANDING));
  assign issue = req & gnt;
  assign skip  = active & wvalid & in_range & zero_strb;
  assign pop   = issue | skip;
  assign ack   = r_valid & (outst != 4'd0);

  assign add  = req ? lane_addr(base, beat, LANE) : 32'd0;
  assign be   = req ? wstrb : 4'd0;
  assign data = req ? wdata : 32'd0;
  assign wen  = ~req;
  assign done = (beat == ({1'b0, len} + 9'd1)) & (outst == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat  <= 9'd0;
      outst <= 4'd0;
    end else if (start) begin
      beat  <= 9'd0;
      outst <= 4'd0;
    end else begin
      if (pop) beat <= beat + 9'd1;
      case ({issue, ack})
        2'b10:   outst <= outst + 4'd1;
        2'b01:   outst <= outst - 4'd1;
        default: outst <= outst;
      endcase
    end
  end

  a_no_stray_ack: assert property (@(posedge clk) disable iff (!rst_n) !(r_valid && outst == 4'd0));

endmodule

`default_nettype wire

// File: rtl/axi2mem_tcdm_wr_if.sv
// Burst command FSM driving two independent TCDM write lanes and returning one write response.
`default_nettype none

module axi2mem_tcdm_wr_if
  import axi2mem_tcdm_wr_if_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ID_WIDTH        = 6
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cmd_req_i,
  output logic                cmd_gnt_o,
  input  logic [31:0]         cmd_add_i,
  input  logic [7:0]          cmd_len_i,
  input  logic [ID_WIDTH-1:0] cmd_id_i,
  input  logic [1:0][31:0]    wr_dat_i,
  input  logic [1:0][3:0]     wr_strb_i,
  input  logic [1:0]          wr_valid_i,
  output logic [1:0]          wr_pop_o,
  output logic [1:0]          tcdm_req_o,
  output logic [1:0][31:0]    tcdm_add_o,
  output logic [1:0]          tcdm_wen_o,
  output logic [1:0][3:0]     tcdm_be_o,
  output logic [1:0][31:0]    tcdm_data_o,
  input  logic [1:0]          tcdm_gnt_i,
  input  logic [1:0]          tcdm_r_valid_i,
  output logic                b_valid_o,
  input  logic                b_ready_i,
  output logic [ID_WIDTH-1:0] b_id_o
);

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  burst_cmd_t          cmd_q;
  logic [ID_WIDTH-1:0] id_q;
  logic                start;
  logic                active;
  logic [1:0]          lane_done;

  assign cmd_gnt_o = (state == ST_IDLE);
  assign start     = cmd_gnt_o & cmd_req_i;
  assign active    = (state == ST_BURST);
  assign b_valid_o = (state == ST_RESP);
  assign b_id_o    = b_valid_o ? id_q : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cmd_req_i) state_nxt = ST_BURST;
      ST_BURST: if (&lane_done) state_nxt = ST_RESP;
      ST_RESP:  if (b_ready_i) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_IDLE;
      cmd_q <= '0;
      id_q  <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        cmd_q.add <= cmd_add_i;
        cmd_q.len <= cmd_len_i;
        id_q      <= cmd_id_i;
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    axi2mem_tcdm_wr_lane #(
      .LANE            (g),
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_lane (
      .clk     (clk_i),
      .rst_n   (rst_ni),
      .start   (start),
      .active  (active),
      .base    (cmd_q.add),
      .len     (cmd_q.len),
      .wdata   (wr_dat_i[g]),
      .wstrb   (wr_strb_i[g]),
      .wvalid  (wr_valid_i[g]),
      .pop     (wr_pop_o[g]),
      .req     (tcdm_req_o[g]),
      .wen     (tcdm_wen_o[g]),
      .add     (tcdm_add_o[g]),
      .be      (tcdm_be_o[g]),
      .data    (tcdm_data_o[g]),
      .gnt     (tcdm_gnt_i[g]),
      .r_valid (tcdm_r_valid_i[g]),
      .done    (lane_done[g])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_axi2mem_tcdm_wr_if.sv
// Directed bench: burst vector table plus hand sequences for backpressure, reset and response hold.
`default_nettype none

module tb_axi2mem_tcdm_wr_if;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_req_i = 1'b0;
  logic             cmd_gnt_o;
  logic [31:0]      cmd_add_i = '0;
  logic [7:0]       cmd_len_i = '0;
  logic [5:0]       cmd_id_i = '0;
  logic [1:0][31:0] wr_dat_i;
  logic [1:0][3:0]  wr_strb_i;
  logic [1:0]       wr_valid_i;
  logic [1:0]       wr_pop_o;
  logic [1:0]       tcdm_req_o;
  logic [1:0][31:0] tcdm_add_o;
  logic [1:0]       tcdm_wen_o;
  logic [1:0][3:0]  tcdm_be_o;
  logic [1:0][31:0] tcdm_data_o;
  logic [1:0]       tcdm_gnt_i;
  logic [1:0]       tcdm_r_valid_i;
  logic             b_valid_o;
  logic             b_ready_i;
  logic [5:0]       b_id_o;

  always #5 clk = ~clk;

  axi2mem_tcdm_wr_if #(.MAX_OUTSTANDING(4), .ID_WIDTH(6)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_req_i(cmd_req_i), .cmd_gnt_o(cmd_gnt_o), .cmd_add_i(cmd_add_i),
    .cmd_len_i(cmd_len_i), .cmd_id_i(cmd_id_i),
    .wr_dat_i(wr_dat_i), .wr_strb_i(wr_strb_i), .wr_valid_i(wr_valid_i), .wr_pop_o(wr_pop_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_add_o(tcdm_add_o), .tcdm_wen_o(tcdm_wen_o),
    .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o), .tcdm_gnt_i(tcdm_gnt_i),
    .tcdm_r_valid_i(tcdm_r_valid_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o)
  );

  typedef struct {
    logic [31:0] add;
    logic [7:0]  len;
    logic [5:0]  id;
    logic [15:0] zmask;   // lane1 beats carrying an all-zero strobe
    int          gd1;     // cycles lane1 grant is withheld
    int          extra;   // surplus buffer entries that must survive the burst
    int          n0, n1;
    logic [31:0] f0, l0, f1, l1;
  } vec_t;

  vec_t vecs[5];

  int          passed = 0;
  int          total = 0;
  logic [35:0] q0[$];
  logic [35:0] q1[$];
  logic [31:0] wa[2][64];
  logic [35:0] wd[2][64];
  int          wn[2];
  int          pend[2];
  int          gblk[2];
  bit          ack_hold = 0;
  bit          b_hold = 0;
  int          bcnt = 0;
  logic [5:0]  bid = '0;
  int          b_cyc = 0;
  int          ack_cyc = 0;
  int          cyc = 0;
  int          wen_err = 0;

  function automatic logic [31:0] dat(input logic [5:0] id, input int l, input int b);
    return {2'b00, id, 8'(l), 16'(b)};
  endfunction

  function automatic logic [3:0] strb_of(input int b);
    return (b % 2 == 1) ? 4'h3 : 4'hF;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Write-buffer and TCDM memory model: inputs change 1 time unit after each rising edge.
  initial begin
    logic [35:0] tmp;
    tcdm_gnt_i = '0; tcdm_r_valid_i = '0; wr_valid_i = '0;
    wr_dat_i = '0; wr_strb_i = '0; b_ready_i = 1'b0;
    wn = '{0, 0}; pend = '{0, 0}; gblk = '{0, 0};
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (wr_pop_o[0] && q0.size() > 0) tmp = q0.pop_front();
        if (wr_pop_o[1] && q1.size() > 0) tmp = q1.pop_front();
        for (int i = 0; i < 2; i++) begin
          if (tcdm_req_o[i] && tcdm_wen_o[i]) wen_err++;
          if (tcdm_req_o[i] && tcdm_gnt_i[i]) begin
            if (wn[i] < 64) begin
              wa[i][wn[i]] = tcdm_add_o[i];
              wd[i][wn[i]] = {tcdm_be_o[i], tcdm_data_o[i]};
            end
            wn[i]++;
            pend[i]++;
          end
          if (tcdm_r_valid_i[i]) ack_cyc = cyc;
        end
        if (b_valid_o && b_ready_i) begin
          bcnt++; bid = b_id_o; b_cyc = cyc;
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        tcdm_gnt_i[i] = (gblk[i] == 0);
        if (gblk[i] > 0) gblk[i]--;
        tcdm_r_valid_i[i] = !ack_hold && rst_n && pend[i] > 0;
        if (tcdm_r_valid_i[i]) pend[i]--;
      end
      wr_valid_i[0] = q0.size() > 0;
      wr_valid_i[1] = q1.size() > 0;
      {wr_strb_i[0], wr_dat_i[0]} = (q0.size() > 0) ? q0[0] : 36'd0;
      {wr_strb_i[1], wr_dat_i[1]} = (q1.size() > 0) ? q1[0] : 36'd0;
      b_ready_i = !b_hold;
    end
  end

  task automatic push_beats(input logic [5:0] id, input int nbeats, input logic [15:0] zmask);
    for (int b = 0; b < nbeats; b++) begin
      q0.push_back({strb_of(b), dat(id, 0, b)});
      q1.push_back({(zmask[b[3:0]] ? 4'h0 : strb_of(b)), dat(id, 1, b)});
    end
  endtask

  task automatic send_cmd(input logic [31:0] add, input logic [7:0] len, input logic [5:0] id,
                          input int gd1);
    gblk[1] = gd1;
    @(posedge clk); #1;
    cmd_req_i = 1'b1; cmd_add_i = add; cmd_len_i = len; cmd_id_i = id;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cmd_gnt_o) break;
    end
    @(posedge clk); #1;
    cmd_req_i = 1'b0;
  endtask

  task automatic wait_b(input int b0, input int limit);
    for (int k = 0; k < limit && bcnt == b0; k++) @(negedge clk);
    #2;
  endtask

  task automatic check_data(input string name, input int l, input logic [5:0] id,
                            input logic [7:0] len, input logic [15:0] zmask);
    int k = 0;
    int err = 0;
    for (int b = 0; b <= int'(len); b++) begin
      if (!(l == 1 && zmask[b[3:0]])) begin
        if (k >= wn[l] || wd[l][k] !== {strb_of(b), dat(id, l, b)}) err++;
        k++;
      end
    end
    check(name, 64'(err), 64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int b0 = bcnt;
    wn = '{0, 0};
    push_beats(v.id, int'(v.len) + 1 + v.extra, v.zmask);
    send_cmd(v.add, v.len, v.id, v.gd1);
    wait_b(b0, 300);
    repeat (3) @(negedge clk);
    #2;
    check("n_writes0", 64'(wn[0]), 64'(v.n0));
    check("n_writes1", 64'(wn[1]), 64'(v.n1));
    check("first_add0", {32'd0, wa[0][0]}, {32'd0, v.f0});
    check("last_add0", {32'd0, wa[0][v.n0-1]}, {32'd0, v.l0});
    check("first_add1", {32'd0, wa[1][0]}, {32'd0, v.f1});
    check("last_add1", {32'd0, wa[1][v.n1-1]}, {32'd0, v.l1});
    check_data("data0", 0, v.id, v.len, 16'd0);
    check_data("data1", 1, v.id, v.len, v.zmask);
    check("b_count", 64'(bcnt - b0), 64'd1);
    check("b_id", {58'd0, bid}, {58'd0, v.id});
    check("b_after_ack", 64'(b_cyc > ack_cyc), 64'd1);
    check("leftover0", 64'(q0.size()), 64'(v.extra));
    check("leftover1", 64'(q1.size()), 64'(v.extra));
    q0.delete(); q1.delete();
  endtask

  initial begin
    int b0;
    vecs[0] = '{32'h0000_1000, 8'd0, 6'd5,  16'h0000, 0, 0, 1, 1,
                32'h0000_1000, 32'h0000_1000, 32'h0000_1004, 32'h0000_1004};
    vecs[1] = '{32'h0000_2000, 8'd3, 6'd9,  16'h0000, 3, 1, 4, 4,
                32'h0000_2000, 32'h0000_2018, 32'h0000_2004, 32'h0000_201C};
    vecs[2] = '{32'h0000_3000, 8'd2, 6'h2A, 16'h0002, 0, 0, 3, 2,
                32'h0000_3000, 32'h0000_3010, 32'h0000_3004, 32'h0000_3014};
    vecs[3] = '{32'hFFFF_FFF8, 8'd1, 6'd63, 16'h0000, 0, 0, 2, 2,
                32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0004};
    vecs[4] = '{32'h0000_0100, 8'd7, 6'd1,  16'h0081, 1, 0, 8, 6,
                32'h0000_0100, 32'h0000_0138, 32'h0000_010C, 32'h0000_0134};

    repeat (3) @(negedge clk);
    check("rst_cmd_gnt", 64'(cmd_gnt_o), 64'd1);
    check("rst_req", 64'(tcdm_req_o), 64'd0);
    check("rst_pop", 64'(wr_pop_o), 64'd0);
    check("rst_b_valid", 64'(b_valid_o), 64'd0);
    check("rst_b_id", 64'(b_id_o), 64'd0);
    check("rst_wen", 64'(tcdm_wen_o), 64'd3);
    check("rst_add", 64'(tcdm_add_o), 64'd0);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #2;

    for (int v = 0; v < 5; v++) run_vec(vecs[v]);

    // Backpressure: with acks withheld each lane stalls at the outstanding limit.
    b0 = bcnt; wn = '{0, 0}; ack_hold = 1;
    push_beats(6'd3, 8, 16'd0);
    send_cmd(32'h0000_4000, 8'd7, 6'd3, 0);
    repeat (10) @(negedge clk);
    check("bp_req_low", 64'(tcdm_req_o), 64'd0);
    check("bp_writes0", 64'(wn[0]), 64'd4);
    check("bp_writes1", 64'(wn[1]), 64'd4);
    check("bp_no_b", 64'(bcnt - b0), 64'd0);
    #2 ack_hold = 0;
    wait_b(b0, 300);
    check("bp_total0", 64'(wn[0]), 64'd8);
    check("bp_total1", 64'(wn[1]), 64'd8);
    check("bp_last_add1", 64'(wa[1][7]), 64'h403C);
    check("bp_b_id", 64'(bid), 64'd3);
    check_data("bp_data1", 1, 6'd3, 8'd7, 16'd0);
    q0.delete(); q1.delete();

    // Asynchronous reset while writes are in flight.
    wn = '{0, 0}; ack_hold = 1;
    push_beats(6'd4, 4, 16'd0);
    send_cmd(32'h0000_5000, 8'd3, 6'd4, 0);
    repeat (2) @(negedge clk);
    check("pre_rst_req", 64'(tcdm_req_o), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req", 64'(tcdm_req_o), 64'd0);
    check("mid_rst_pop", 64'(wr_pop_o), 64'd0);
    check("mid_rst_b_valid", 64'(b_valid_o), 64'd0);
    check("mid_rst_cmd_gnt", 64'(cmd_gnt_o), 64'd1);
    pend = '{0, 0}; q0.delete(); q1.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1; ack_hold = 0;

    // Response must hold steady until accepted, then a new command is granted.
    b0 = bcnt; wn = '{0, 0}; b_hold = 1;
    push_beats(6'd7, 1, 16'd0);
    send_cmd(32'h0000_6000, 8'd0, 6'd7, 0);
    for (int k = 0; k < 100 && !b_valid_o; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("hold_b_valid", 64'(b_valid_o), 64'd1);
    check("hold_b_id", 64'(b_id_o), 64'd7);
    check("hold_no_hs", 64'(bcnt - b0), 64'd0);
    check("post_rst_add0", 64'(wa[0][0]), 64'h6000);
    check("post_rst_add1", 64'(wa[1][0]), 64'h6004);
    #2 b_hold = 0;
    wait_b(b0, 50);
    check("post_rst_b_count", 64'(bcnt - b0), 64'd1);
    @(negedge clk);
    check("next_cmd_gnt", 64'(cmd_gnt_o), 64'd1);
    check("wen_during_req", 64'(wen_err), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
